// File: rtl/sram_like_responder.sv
// In-order SRAM-like responder: accepts one request per cycle, data_ok LATENCY cycles after acceptance.
// Up to MAX_OUTST in flight; addr_ok is the only throttle and data_ok cannot be back-pressured.
module sram_like_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [31:0]          mem_q [DEPTH];

  logic                 ent_vld_q   [MAX_OUTST];
  logic                 ent_vld_d   [MAX_OUTST];
  logic [2:0]           ent_cnt_q   [MAX_OUTST];
  logic [2:0]           ent_cnt_d   [MAX_OUTST];
  logic                 ent_wr_q    [MAX_OUTST];
  logic                 ent_wr_d    [MAX_OUTST];
  logic [3:0]           ent_strb_q  [MAX_OUTST];
  logic [3:0]           ent_strb_d  [MAX_OUTST];
  logic [ADDR_BITS-1:0] ent_idx_q   [MAX_OUTST];
  logic [ADDR_BITS-1:0] ent_idx_d   [MAX_OUTST];
  logic [31:0]          ent_wdata_q [MAX_OUTST];
  logic [31:0]          ent_wdata_d [MAX_OUTST];

  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [2:0]           outst_q, outst_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 retire, accept, addr_ok_c;
  logic                 head_wr;
  logic [3:0]           head_strb;
  logic [ADDR_BITS-1:0] head_idx;
  logic [31:0]          head_wdata, head_rd;
  logic                 unused_bits;

  assign unused_bits = ^{size, addr[31:ADDR_BITS+2], addr[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_wr    = ent_wr_q[head_q];
  assign head_strb  = ent_strb_q[head_q];
  assign head_idx   = ent_idx_q[head_q];
  assign head_wdata = ent_wdata_q[head_q];
  // Asynchronous read so a read retiring right after a write sees the new word.
  assign head_rd    = mem_q[head_idx];

  always_comb begin
    retire    = !reset && ent_vld_q[head_q] && (ent_cnt_q[head_q] == 3'd1);
    addr_ok_c = !reset && ((outst_q < 3'(MAX_OUTST)) || retire);
    accept    = req && addr_ok_c;

    head_d  = head_q;
    tail_d  = tail_q;
    outst_d = outst_q + {2'b0, accept} - {2'b0, retire};
    rdata_d = rdata_q;
    for (int i = 0; i < MAX_OUTST; i++) begin
      ent_vld_d[i]   = ent_vld_q[i];
      ent_wr_d[i]    = ent_wr_q[i];
      ent_strb_d[i]  = ent_strb_q[i];
      ent_idx_d[i]   = ent_idx_q[i];
      ent_wdata_d[i] = ent_wdata_q[i];
      ent_cnt_d[i]   = (ent_vld_q[i] && ent_cnt_q[i] > 3'd1) ? ent_cnt_q[i] - 3'd1 : ent_cnt_q[i];
    end

    if (retire) begin
      ent_vld_d[head_q] = 1'b0;
      head_d            = ptr_inc(head_q);
      if (!head_wr) rdata_d = head_rd;
    end

    // Applied after retire so a full queue can refill the slot just freed.
    if (accept) begin
      ent_vld_d[tail_q]   = 1'b1;
      ent_cnt_d[tail_q]   = 3'(LATENCY);
      ent_wr_d[tail_q]    = wr;
      ent_strb_d[tail_q]  = wstrb;
      ent_idx_d[tail_q]   = addr[ADDR_BITS+1:2];
      ent_wdata_d[tail_q] = wdata;
      tail_d              = ptr_inc(tail_q);
    end

    if (reset) begin
      head_d  = '0;
      tail_d  = '0;
      outst_d = '0;
      rdata_d = '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        ent_vld_d[i] = 1'b0;
        ent_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    outst_q <= outst_d;
    rdata_q <= rdata_d;
    for (int i = 0; i < MAX_OUTST; i++) begin
      ent_vld_q[i]   <= ent_vld_d[i];
      ent_cnt_q[i]   <= ent_cnt_d[i];
      ent_wr_q[i]    <= ent_wr_d[i];
      ent_strb_q[i]  <= ent_strb_d[i];
      ent_idx_q[i]   <= ent_idx_d[i];
      ent_wdata_q[i] <= ent_wdata_d[i];
    end
  end

  // Memory is never reset; writes land only when their entry retires.
  always_ff @(posedge clk) begin
    if (retire && head_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (head_strb[b]) mem_q[head_idx][8*b +: 8] <= head_wdata[8*b +: 8];
      end
    end
  end

  assign addr_ok = addr_ok_c;
  assign data_ok = retire;
  assign rdata   = reset ? 32'h0 : ((retire && !head_wr) ? head_rd : rdata_q);

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: default instance (LATENCY=2, MAX_OUTST=2) plus a LATENCY=4 instance for the in-flight limit.
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req4;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok0, data_ok0, addr_ok4, data_ok4;
  logic [31:0] rdata0, rdata4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_like_responder #(.ADDR_BITS(10), .LATENCY(2), .MAX_OUTST(2)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0)
  );

  sram_like_responder #(.ADDR_BITS(10), .LATENCY(4), .MAX_OUTST(2)) dut4 (
    .clk(clk), .reset(reset), .req(req4), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok4), .data_ok(data_ok4), .rdata(rdata4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request on the default instance for one cycle; it must be accepted.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2; req0 = 1'b1;
    chk("issue_addr_ok", {31'b0, addr_ok0}, 32'd1);
    tick();
    req0 = 1'b0;
  endtask

  initial begin
    logic [9:0] dok4_exp;
    logic [4:0] aok4_exp;
    reset = 1'b1; req0 = 1'b0; req4 = 1'b0; wr = 1'b0; size = 2'd2;
    wstrb = 4'h0; addr = '0; wdata = '0;

    tick(); tick();
    chk("rst_addr_ok", {31'b0, addr_ok0}, 32'd0);
    chk("rst_data_ok", {31'b0, data_ok0}, 32'd0);
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_addr_ok4", {31'b0, addr_ok4}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_addr_ok", {31'b0, addr_ok0}, 32'd1);
    tick();

    // Single write then read: data_ok at T0+2 and T0+5.
    issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    chk("wr_dok_t1", {31'b0, data_ok0}, 32'd0);
    tick();
    chk("wr_dok_t2", {31'b0, data_ok0}, 32'd1);
    tick();
    chk("rd_dok_t3", {31'b0, data_ok0}, 32'd0);
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    chk("rd_dok_t4", {31'b0, data_ok0}, 32'd0);
    tick();
    chk("rd_dok_t5", {31'b0, data_ok0}, 32'd1);
    chk("rd_data_t5", rdata0, 32'hDEADBEEF);
    tick();
    chk("idle_dok", {31'b0, data_ok0}, 32'd0);
    chk("idle_rdata_hold", rdata0, 32'hDEADBEEF);

    // Byte lanes: strobe 5 updates bytes 0 and 2.
    issue(1'b1, 32'h200, 32'h11223344, 4'hF);
    issue(1'b1, 32'h200, 32'hAABBCCDD, 4'h5);
    issue(1'b0, 32'h200, 32'h0, 4'h0);
    chk("wr_retire_rdata_hold", rdata0, 32'hDEADBEEF);
    tick();
    chk("strb5_dok", {31'b0, data_ok0}, 32'd1);
    chk("strb5_rdata", rdata0, 32'h11BB33DD);
    issue(1'b1, 32'h200, 32'h11223344, 4'hF);
    issue(1'b1, 32'h200, 32'hAABBCCDD, 4'h4);
    issue(1'b0, 32'h200, 32'h0, 4'h0);
    tick();
    chk("strb4_rdata", rdata0, 32'h11BB3344);
    issue(1'b1, 32'h200, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 32'h200, 32'h0, 4'h0);
    tick();
    chk("strb0_dok", {31'b0, data_ok0}, 32'd1);
    chk("strb0_rdata", rdata0, 32'h11BB3344);
    tick(); tick();

    // Back-to-back alternating write/read on 0x40.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        wr = (k % 2 == 0); addr = 32'h40; wdata = 32'hA0000000 + k; wstrb = 4'hF; req0 = 1'b1;
        chk("b2b_addr_ok", {31'b0, addr_ok0}, 32'd1);
      end else begin
        req0 = 1'b0;
      end
      chk("b2b_dok", {31'b0, data_ok0}, (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
      if (k >= 2 && ((k - 2) % 2 == 1)) chk("b2b_rdata", rdata0, 32'hA0000000 + k - 3);
      tick();
    end

    // In-flight limit on the LATENCY=4 instance; third request held until accepted.
    dok4_exp = 10'b01_0011_0000;
    aok4_exp = 5'b10011;
    for (int k = 0; k < 10; k++) begin
      wr = 1'b0; addr = 32'h300 + 4 * k; req4 = (k <= 4);
      if (k <= 4) chk("lim_addr_ok", {31'b0, addr_ok4}, {31'b0, aok4_exp[k]});
      chk("lim_dok", {31'b0, data_ok4}, {31'b0, dok4_exp[k]});
      tick();
    end
    req4 = 1'b0;

    // Reset one cycle after a write is accepted drops that write.
    issue(1'b1, 32'h80, 32'h12345678, 4'hF);
    tick(); tick();
    issue(1'b1, 32'h80, 32'h55555555, 4'hF);
    reset = 1'b1;
    #1;
    chk("mid_rst_dok", {31'b0, data_ok0}, 32'd0);
    chk("mid_rst_rdata", rdata0, 32'h0);
    chk("mid_rst_addr_ok", {31'b0, addr_ok0}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("after_rst_dok", {31'b0, data_ok0}, 32'd0);
    chk("after_rst_addr_ok", {31'b0, addr_ok0}, 32'd1);
    tick();
    chk("after_rst_dok2", {31'b0, data_ok0}, 32'd0);
    issue(1'b0, 32'h80, 32'h0, 4'h0);
    tick();
    chk("after_rst_rd_dok", {31'b0, data_ok0}, 32'd1);
    chk("after_rst_rdata", rdata0, 32'h12345678);
    tick();

    // Address wrap and ignored low bits.
    issue(1'b1, 32'h1008, 32'hCAFEF00D, 4'hF);
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    issue(1'b0, 32'hB, 32'h0, 4'h0);
    chk("wrap_rdata", rdata0, 32'hCAFEF00D);
    tick();
    chk("wrap_lowbits_dok", {31'b0, data_ok0}, 32'd1);
    chk("wrap_lowbits_rdata", rdata0, 32'hCAFEF00D);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
